// File: rtl/maint_scheduler.sv
// Use/maintenance sequencer: grants use cycles, locks out at the use limit or on a
// RUN timeout, and runs fixed-length maintenance cycles that reset the use count.
module maint_scheduler #(
    parameter logic [7:0] CYCLE_LIMIT = 8'd10,
    parameter logic [7:0] WARN_MARGIN = 8'd2,
    parameter int         MAINT_LEN   = 4,
    parameter int         RUN_MAX     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       use_req,
    input  logic       use_done,
    input  logic       maint_req,
    output logic       use_ack,
    output logic       maint_busy,
    output logic       warn,
    output logic       lockout,
    output logic       fault,
    output logic [7:0] use_count,
    output logic [7:0] maint_count,
    output logic [7:0] msj
);
    localparam int         TMAX    = (RUN_MAX > MAINT_LEN) ? RUN_MAX : MAINT_LEN;
    localparam int         TW      = $clog2(TMAX);
    localparam logic [7:0] WARN_TH = CYCLE_LIMIT - WARN_MARGIN;

    typedef enum logic [1:0] {IDLE, RUN, MAINT, LOCK} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          pend_q, pend_d;
    logic          use_ack_q, use_ack_d;
    logic          fault_q, fault_d;
    logic          warn_q;
    logic [7:0]    use_count_q, use_count_d;
    logic [7:0]    maint_count_q, maint_count_d;
    logic [7:0]    msj_q;

    always_comb begin
        state_d       = state_q;
        tmr_d         = tmr_q + TW'(1);
        pend_d        = pend_q;
        use_ack_d     = 1'b0;
        fault_d       = fault_q;
        use_count_d   = use_count_q;
        maint_count_d = maint_count_q;
        case (state_q)
            IDLE: begin
                tmr_d = '0;
                if (maint_req || pend_q) begin
                    state_d = MAINT;
                    pend_d  = 1'b0;
                end else if (fault_q || use_count_q == CYCLE_LIMIT) begin
                    state_d = LOCK;
                end else if (use_req) begin
                    state_d     = RUN;
                    use_ack_d   = 1'b1;
                    use_count_d = use_count_q + 8'd1;
                end
            end
            RUN: begin
                // A maintenance request during a use is deferred, never dropped
                if (maint_req) pend_d = 1'b1;
                if (use_done) begin
                    state_d = IDLE;
                    tmr_d   = '0;
                end else if (tmr_q == TW'(RUN_MAX - 1)) begin
                    state_d = LOCK;
                    fault_d = 1'b1;
                    tmr_d   = '0;
                end
            end
            MAINT: begin
                if (tmr_q == TW'(MAINT_LEN - 1)) begin
                    state_d     = IDLE;
                    tmr_d       = '0;
                    use_count_d = 8'd0;
                    fault_d     = 1'b0;
                    if (maint_count_q != 8'hFF) maint_count_d = maint_count_q + 8'd1;
                end
            end
            LOCK: begin
                tmr_d = '0;
                if (maint_req) begin
                    state_d = MAINT;
                    pend_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            tmr_q         <= '0;
            pend_q        <= 1'b0;
            use_ack_q     <= 1'b0;
            fault_q       <= 1'b0;
            warn_q        <= 1'b0;
            use_count_q   <= 8'd0;
            maint_count_q <= 8'd0;
            msj_q         <= 8'h00;
        end else begin
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            pend_q        <= pend_d;
            use_ack_q     <= use_ack_d;
            fault_q       <= fault_d;
            use_count_q   <= use_count_d;
            maint_count_q <= maint_count_d;
            // Status outputs are derived from the current registers, so they trail state by one cycle
            warn_q        <= (use_count_q >= WARN_TH) && (state_q != LOCK);
            msj_q         <= (state_q == LOCK) ? 8'hFF : maint_count_q;
        end
    end

    assign use_ack     = use_ack_q;
    assign maint_busy  = (state_q == MAINT);
    assign lockout     = (state_q == LOCK);
    assign fault       = fault_q;
    assign warn        = warn_q;
    assign use_count   = use_count_q;
    assign maint_count = maint_count_q;
    assign msj         = msj_q;

endmodule

// File: tb/tb_maint_scheduler.sv
// Directed scenarios plus random traffic, checked every cycle against a behavioural model.
module tb_maint_scheduler;
    localparam int LIM       = 10;
    localparam int MARGIN    = 2;
    localparam int MAINT_LEN = 4;
    localparam int RUN_MAX   = 16;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_MAINT = 2;
    localparam int M_LOCK  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       use_req = 1'b0;
    logic       use_done = 1'b0;
    logic       maint_req = 1'b0;
    logic       use_ack, maint_busy, warn, lockout, fault;
    logic [7:0] use_count, maint_count, msj;

    int n_checks = 0;
    int n_errors = 0;
    int ack_seen = 0;
    int busy_seen = 0;

    // Model state: current mode, cycles spent in it, and the visible values
    int m_mode, m_age, m_cnt, m_mcnt, m_warn, m_msj;
    bit m_ack, m_fault, m_pend;

    maint_scheduler #(
        .CYCLE_LIMIT(8'(LIM)),
        .WARN_MARGIN(8'(MARGIN)),
        .MAINT_LEN  (MAINT_LEN),
        .RUN_MAX    (RUN_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .use_req    (use_req),
        .use_done   (use_done),
        .maint_req  (maint_req),
        .use_ack    (use_ack),
        .maint_busy (maint_busy),
        .warn       (warn),
        .lockout    (lockout),
        .fault      (fault),
        .use_count  (use_count),
        .maint_count(maint_count),
        .msj        (msj)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic void enter(input int mode);
        m_mode = mode;
        m_age  = 0;
    endfunction

    task automatic model_step(input bit r, input bit ur, input bit ud, input bit mr);
        int nxt_warn, nxt_msj;
        if (!r) begin
            m_mode = M_IDLE; m_age = 0; m_cnt = 0; m_mcnt = 0; m_warn = 0; m_msj = 0;
            m_ack = 0; m_fault = 0; m_pend = 0;
            return;
        end
        nxt_warn = (m_cnt >= LIM - MARGIN && m_mode != M_LOCK) ? 1 : 0;
        nxt_msj  = (m_mode == M_LOCK) ? 255 : m_mcnt;
        m_ack    = 0;
        if (m_mode == M_IDLE) begin
            if (mr || m_pend) begin
                m_pend = 0;
                enter(M_MAINT);
            end else if (m_fault || m_cnt == LIM) begin
                enter(M_LOCK);
            end else if (ur) begin
                m_ack = 1;
                m_cnt = m_cnt + 1;
                enter(M_RUN);
            end
        end else if (m_mode == M_RUN) begin
            if (mr) m_pend = 1;
            if (ud) enter(M_IDLE);
            else if (m_age + 1 >= RUN_MAX) begin
                m_fault = 1;
                enter(M_LOCK);
            end else m_age++;
        end else if (m_mode == M_MAINT) begin
            if (m_age + 1 >= MAINT_LEN) begin
                m_cnt   = 0;
                m_fault = 0;
                m_mcnt  = (m_mcnt < 255) ? m_mcnt + 1 : 255;
                enter(M_IDLE);
            end else m_age++;
        end else begin
            if (mr) begin
                m_pend = 0;
                enter(M_MAINT);
            end
        end
        m_warn = nxt_warn;
        m_msj  = nxt_msj;
    endtask

    // Per-cycle compare against the model
    initial begin
        forever begin
            @(posedge clk);
            model_step(rst, use_req, use_done, maint_req);
            @(negedge clk);
            chk("use_ack",     {7'd0, use_ack},    8'(m_ack));
            chk("maint_busy",  {7'd0, maint_busy}, 8'(m_mode == M_MAINT));
            chk("lockout",     {7'd0, lockout},    8'(m_mode == M_LOCK));
            chk("fault",       {7'd0, fault},      8'(m_fault));
            chk("warn",        {7'd0, warn},       8'(m_warn));
            chk("use_count",   use_count,          8'(m_cnt));
            chk("maint_count", maint_count,        8'(m_mcnt));
            chk("msj",         msj,                8'(m_msj));
            if (use_ack === 1'b1) ack_seen++;
            if (maint_busy === 1'b1) busy_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_use();
        use_req = 1'b1; tick(); use_req = 1'b0;
        tick(); tick();
        use_done = 1'b1; tick(); use_done = 1'b0;
        tick();
    endtask

    task automatic do_maint();
        maint_req = 1'b1; tick(); maint_req = 1'b0;
        repeat (MAINT_LEN) tick();
    endtask

    initial begin
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        chk("reset_msj", msj, 8'h00);

        // T1: ten uses then lockout
        ack_seen = 0;
        for (int i = 0; i < LIM; i++) begin
            do_use();
            if (i == 6) chk("t1_warn_at7", {7'd0, warn}, 8'd0);
            if (i == 7) chk("t1_warn_at8", {7'd0, warn}, 8'd1);
        end
        tick();
        chk("t1_acks", 8'(ack_seen), 8'd10);
        chk("t1_lockout", {7'd0, lockout}, 8'd1);
        chk("t1_msj", msj, 8'hFF);
        chk("t1_count", use_count, 8'd10);
        use_req = 1'b1; repeat (5) tick(); use_req = 1'b0;
        chk("t1_no_11th_ack", 8'(ack_seen), 8'd10);
        $display("T1 uses granted=%0d lockout=%0d msj=%h", ack_seen, lockout, msj);

        // T2: maintenance out of lockout
        busy_seen = 0;
        do_maint();
        tick();
        chk("t2_busy_cycles", 8'(busy_seen), 8'd4);
        chk("t2_count", use_count, 8'd0);
        chk("t2_mcount", maint_count, 8'd1);
        chk("t2_msj", msj, 8'h01);
        chk("t2_lockout", {7'd0, lockout}, 8'd0);
        $display("T2 maint_count=%0d msj=%h", maint_count, msj);

        // T3: RUN timeout
        use_req = 1'b1; repeat (20) tick(); use_req = 1'b0;
        chk("t3_fault", {7'd0, fault}, 8'd1);
        chk("t3_lockout", {7'd0, lockout}, 8'd1);
        do_maint(); tick();
        chk("t3_fault_cleared", {7'd0, fault}, 8'd0);
        $display("T3 timeout fault cleared, maint_count=%0d", maint_count);

        // T4: maintenance requested mid-use, use_req held through MAINT
        ack_seen = 0;
        use_req = 1'b1; tick(); use_req = 1'b0;
        maint_req = 1'b1; tick(); maint_req = 1'b0;
        tick();
        use_done = 1'b1; use_req = 1'b1; tick(); use_done = 1'b0;
        chk("t4_idle_gap", {7'd0, maint_busy}, 8'd0);
        tick();
        chk("t4_maint", {7'd0, maint_busy}, 8'd1);
        chk("t4_no_ack_in_maint", 8'(ack_seen), 8'd1);
        repeat (6) tick();
        chk("t4_ack_after_maint", 8'(ack_seen), 8'd2);
        use_req = 1'b0; use_done = 1'b1; tick(); use_done = 1'b0; tick();
        $display("T4 deferred maintenance, acks=%0d", ack_seen);

        // T5: reset aborts maintenance
        rst = 1'b0; tick(); rst = 1'b1;
        maint_req = 1'b1; tick(); maint_req = 1'b0;
        tick();
        rst = 1'b0; tick();
        chk("t5_busy", {7'd0, maint_busy}, 8'd0);
        chk("t5_msj", msj, 8'h00);
        rst = 1'b1; repeat (3) tick();
        chk("t5_mcount", maint_count, 8'd0);
        $display("T5 reset mid-maint, maint_count=%0d", maint_count);

        // T6: maintenance tally saturation
        for (int i = 0; i < 256; i++) do_maint();
        tick();
        chk("t6_sat", maint_count, 8'hFF);
        for (int i = 0; i < LIM; i++) do_use();
        tick();
        chk("t6_lock_msj", msj, 8'hFF);
        do_maint(); tick();
        chk("t6_still_sat", maint_count, 8'hFF);
        chk("t6_msj_tally", msj, 8'hFF);
        $display("T6 maint_count=%h", maint_count);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 199) != 0);
            use_req   = ($urandom_range(0, 1) == 1);
            use_done  = ($urandom_range(0, 99) < 15);
            maint_req = ($urandom_range(0, 99) < 4);
            tick();
        end
        rst = 1'b1; use_req = 1'b0; use_done = 1'b0; maint_req = 1'b0;
        tick(); tick();
        $display("Random phase complete");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
